// File: rtl/onehot_step_counter.sv
`timescale 1ns/1ps
// onehot_step_counter
//   A single lit bit walks across WIDTH positions, one position per step
//   event. It supports up/down travel, four end-of-range behaviours,
//   optional rising-edge qualification of the trigger, and synchronous
//   clear/load. It also reports a binary index and a wrap pulse.
//
// Parameters
//   WIDTH      number of positions (>= 2)
//   MODE       0 WRAP_EMPTY, 1 ROLL, 2 BOUNCE, 3 SATURATE
//   EDGE_TRIG  1: step on trigger rising edge, 0: step while trigger high
//
// Ports
//   clk       system clock, all state on posedge
//   reset     asynchronous, active-low reset
//   trigger   advance request
//   dir       0 = up (toward bit WIDTH-1), 1 = down (toward bit 0)
//   clear     synchronous return to EMPTY
//   load      synchronous load of position load_idx (ignored if out of range)
//   load_idx  position to light on load
//   out       one-hot position, zero when EMPTY
//   idx       binary index of the lit bit, zero when EMPTY
//   active    out is non-zero
//   at_end    lit bit is the terminal bit for the current travel direction
//   wrap      one-cycle pulse on the step that leaves (or parks on) the terminal bit
module onehot_step_counter #(
  parameter int WIDTH     = 16,
  parameter int MODE      = 0,
  parameter bit EDGE_TRIG = 1'b1,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [WIDTH-1:0] out,
  output logic [IDX_W-1:0] idx,
  output logic             active,
  output logic             at_end,
  output logic             wrap
);

  localparam int MODE_WRAP_EMPTY = 0;
  localparam int MODE_ROLL       = 1;
  localparam int MODE_BOUNCE     = 2;

  localparam logic [WIDTH-1:0] LSB_BIT   = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_BIT   = LSB_BIT << (WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W:0]   WIDTH_EXT = (IDX_W + 1)'(WIDTH);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  logic   cur_dir;
  logic   trig_q;

  logic   step;
  logic   load_ok;
  logic   move_dir;
  logic   at_term;

  state_t           state_n;
  logic             cur_dir_n;
  logic [WIDTH-1:0] out_n;
  logic [IDX_W-1:0] idx_n;
  logic             wrap_n;
  logic             at_end_n;

  assign step    = EDGE_TRIG ? (trigger & ~trig_q) : trigger;
  assign load_ok = load && ({1'b0, load_idx} < WIDTH_EXT);

  // BOUNCE follows its own travel direction while lit; every other mode
  // moves the way dir points on the cycle the step is taken.
  assign move_dir = (MODE == MODE_BOUNCE && state != EMPTY) ? cur_dir : dir;
  assign at_term  = move_dir ? out[0] : out[WIDTH-1];

  always_comb begin
    state_n   = state;
    cur_dir_n = cur_dir;
    out_n     = out;
    idx_n     = idx;
    wrap_n    = 1'b0;
    if (clear) begin
      state_n   = EMPTY;
      out_n     = '0;
      idx_n     = '0;
      cur_dir_n = dir;
    end else if (load_ok) begin
      state_n   = RUN;
      out_n     = LSB_BIT << load_idx;
      idx_n     = load_idx;
      cur_dir_n = dir;
    end else if (step) begin
      if (state == EMPTY) begin
        state_n   = RUN;
        out_n     = dir ? MSB_BIT : LSB_BIT;
        idx_n     = dir ? LAST_IDX : '0;
        cur_dir_n = dir;
      end else if (!at_term) begin
        state_n = RUN;
        out_n   = move_dir ? (out >> 1) : (out << 1);
        idx_n   = move_dir ? (idx - IDX_ONE) : (idx + IDX_ONE);
        if (MODE != MODE_BOUNCE) begin
          cur_dir_n = dir;
        end
      end else begin
        case (MODE)
          MODE_WRAP_EMPTY: begin
            state_n   = EMPTY;
            out_n     = '0;
            idx_n     = '0;
            wrap_n    = 1'b1;
            cur_dir_n = dir;
          end
          MODE_ROLL: begin
            out_n     = move_dir ? MSB_BIT : LSB_BIT;
            idx_n     = move_dir ? LAST_IDX : '0;
            wrap_n    = 1'b1;
            cur_dir_n = dir;
          end
          MODE_BOUNCE: begin
            cur_dir_n = ~cur_dir;
            out_n     = move_dir ? (out << 1) : (out >> 1);
            idx_n     = move_dir ? (idx + IDX_ONE) : (idx - IDX_ONE);
            wrap_n    = 1'b1;
          end
          default: begin
            // SATURATE: park on the terminal bit, flag only on arrival
            state_n   = HOLD;
            wrap_n    = (state != HOLD);
            cur_dir_n = dir;
          end
        endcase
      end
    end
    at_end_n = (state_n != EMPTY) && (cur_dir_n ? out_n[0] : out_n[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      cur_dir <= 1'b0;
      trig_q  <= 1'b0;
      out     <= '0;
      idx     <= '0;
      active  <= 1'b0;
      at_end  <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_n;
      cur_dir <= cur_dir_n;
      trig_q  <= trigger;
      out     <= out_n;
      idx     <= idx_n;
      active  <= (state_n != EMPTY);
      at_end  <= at_end_n;
      wrap    <= wrap_n;
    end
  end

endmodule

// File: tb/tb_onehot_step_counter.sv
`timescale 1ns/1ps
// Testbench for onehot_step_counter: five instances covering every end
// mode, both trigger qualifications and a non-power-of-two width, checked
// every cycle against a position-number model plus literal expectations.
module tb_onehot_step_counter;

  localparam int N = 5;

  function automatic int w_of(int g);
    case (g)
      0: return 16;
      1: return 8;
      2: return 4;
      3: return 4;
      default: return 12;
    endcase
  endfunction

  function automatic int mode_of(int g);
    case (g)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit edge_of(int g);
    return (g != 4);
  endfunction

  logic clk;
  logic reset;
  logic [N-1:0] trig, dirv, clr, ld;
  logic [3:0] lidx [N];
  logic [N-1:0][15:0] o;
  logic [N-1:0][3:0]  ix;
  logic [N-1:0] act, ae, wr;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W  = w_of(g);
    localparam int IW = $clog2(W);
    logic [W-1:0]  o_raw;
    logic [IW-1:0] i_raw;
    onehot_step_counter #(
      .WIDTH(W), .MODE(mode_of(g)), .EDGE_TRIG(edge_of(g))
    ) u_dut (
      .clk(clk), .reset(reset), .trigger(trig[g]), .dir(dirv[g]),
      .clear(clr[g]), .load(ld[g]), .load_idx(lidx[g][IW-1:0]),
      .out(o_raw), .idx(i_raw), .active(act[g]), .at_end(ae[g]), .wrap(wr[g])
    );
    assign o[g]  = 16'(o_raw);
    assign ix[g] = 4'(i_raw);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the lit position as a plain integer (-1 = nothing lit).
  typedef struct {
    int pos;
    bit hold;
    bit cdir;
    bit tq;
    bit wrap;
  } mstate_t;

  function automatic mstate_t m_init();
    mstate_t s;
    s.pos = -1; s.hold = 0; s.cdir = 0; s.tq = 0; s.wrap = 0;
    return s;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int w, int mode, bit edg,
                                    bit t, bit d_in, bit c, bit l, int li);
    mstate_t n;
    bit st;
    bit d;
    bit term;
    n = s;
    st = edg ? (t && !s.tq) : t;
    n.tq = t;
    n.wrap = 0;
    if (c) begin
      n.pos = -1; n.hold = 0; n.cdir = d_in;
    end else if (l && li < w) begin
      n.pos = li; n.hold = 0; n.cdir = d_in;
    end else if (st) begin
      if (s.pos < 0) begin
        n.pos = d_in ? w - 1 : 0; n.cdir = d_in;
      end else begin
        d = (mode == 2) ? s.cdir : d_in;
        term = d ? (s.pos == 0) : (s.pos == w - 1);
        if (!term) begin
          n.pos = d ? s.pos - 1 : s.pos + 1;
          n.hold = 0;
          if (mode != 2) n.cdir = d_in;
        end else if (mode == 0) begin
          n.pos = -1; n.wrap = 1; n.cdir = d_in;
        end else if (mode == 1) begin
          n.pos = d ? w - 1 : 0; n.wrap = 1; n.cdir = d_in;
        end else if (mode == 2) begin
          n.pos = d ? s.pos + 1 : s.pos - 1; n.cdir = !d; n.wrap = 1;
        end else begin
          n.wrap = !s.hold; n.hold = 1; n.cdir = d_in;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] exp_out(mstate_t s);
    logic [15:0] one;
    one = 16'd1;
    return (s.pos < 0) ? 16'd0 : (one << s.pos);
  endfunction

  function automatic logic [15:0] exp_idx(mstate_t s);
    return (s.pos < 0) ? 16'd0 : 16'(s.pos);
  endfunction

  function automatic bit exp_end(mstate_t s, int w);
    return (s.pos >= 0) && (s.cdir ? (s.pos == 0) : (s.pos == w - 1));
  endfunction

  mstate_t ms [N];

  always @(posedge clk or negedge reset) begin
    for (int g = 0; g < N; g++) begin
      if (!reset) ms[g] <= m_init();
      else ms[g] <= mstep(ms[g], w_of(g), mode_of(g), edge_of(g), trig[g],
                          dirv[g], clr[g], ld[g], int'(lidx[g]));
    end
  end

  int compared;
  int mismatched;
  bit run_chk;
  bit lit_on;
  int lit_g;
  logic [15:0] lit_out;
  bit lit_wrap;
  bit lit_end;

  task automatic chk(string nm, int g, logic [15:0] a, logic [15:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s u%0d @%0t: got 0x%0h, expected 0x%0h", nm, g, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      for (int g = 0; g < N; g++) begin
        chk("out", g, o[g], exp_out(ms[g]));
        chk("idx", g, 16'(ix[g]), exp_idx(ms[g]));
        chk("active", g, 16'(act[g]), 16'(ms[g].pos >= 0));
        chk("at_end", g, 16'(ae[g]), 16'(exp_end(ms[g], w_of(g))));
        chk("wrap", g, 16'(wr[g]), 16'(ms[g].wrap));
      end
      if (lit_on) begin
        chk("lit_out", lit_g, o[lit_g], lit_out);
        chk("lit_wrap", lit_g, 16'(wr[lit_g]), 16'(lit_wrap));
        chk("lit_at_end", lit_g, 16'(ae[lit_g]), 16'(lit_end));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle sample, then one cycle of trigger high.
  task automatic pulse(int g);
    tick();
    trig[g] = 1'b1;
    tick();
    trig[g] = 1'b0;
  endtask

  task automatic expect_lit(int g, logic [15:0] eo, bit ew, bit ee);
    lit_g = g; lit_out = eo; lit_wrap = ew; lit_end = ee;
    lit_on = 1'b1;
    @(negedge clk);
    #1;
    lit_on = 1'b0;
  endtask

  task automatic do_load(int g, logic [3:0] v, bit d);
    tick();
    dirv[g] = d;
    lidx[g] = v;
    ld[g] = 1'b1;
    tick();
    ld[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit %0d ns reached", 200000);
    $fatal(1, "timeout");
  end

  initial begin
    compared = 0; mismatched = 0; run_chk = 0; lit_on = 0;
    lit_g = 0; lit_out = '0; lit_wrap = 0; lit_end = 0;
    trig = '0; dirv = '0; clr = '0; ld = '0;
    for (int g = 0; g < N; g++) lidx[g] = '0;
    reset = 1'b0;
    tick();
    tick();
    run_chk = 1'b1;
    expect_lit(0, 16'h0000, 0, 0);
    reset = 1'b1;

    // 16-bit WRAP_EMPTY walk up and off the end
    for (int i = 1; i <= 17; i++) begin
      pulse(0);
      if (i == 1)  expect_lit(0, 16'h0001, 0, 0);
      if (i == 7)  expect_lit(0, 16'h0040, 0, 0);
      if (i == 16) expect_lit(0, 16'h8000, 0, 1);
      if (i == 17) expect_lit(0, 16'h0000, 1, 0);
    end

    // ROLL, width 8
    do_load(1, 4'd7, 1'b0);
    expect_lit(1, 16'h0080, 0, 1);
    pulse(1);
    expect_lit(1, 16'h0001, 1, 0);
    dirv[1] = 1'b1;
    pulse(1);
    expect_lit(1, 16'h0080, 1, 0);

    // BOUNCE, width 4; dir changes are ignored while lit
    do_load(2, 4'd0, 1'b0);
    expect_lit(2, 16'h1, 0, 0);
    pulse(2); expect_lit(2, 16'h2, 0, 0);
    dirv[2] = 1'b1;
    pulse(2); expect_lit(2, 16'h4, 0, 0);
    pulse(2); expect_lit(2, 16'h8, 0, 1);
    pulse(2); expect_lit(2, 16'h4, 1, 0);
    pulse(2); expect_lit(2, 16'h2, 0, 0);
    pulse(2); expect_lit(2, 16'h1, 0, 1);

    // SATURATE, width 4
    do_load(3, 4'd3, 1'b0);
    expect_lit(3, 16'h8, 0, 1);
    pulse(3); expect_lit(3, 16'h8, 1, 1);
    pulse(3); expect_lit(3, 16'h8, 0, 1);
    pulse(3); expect_lit(3, 16'h8, 0, 1);
    dirv[3] = 1'b1;
    pulse(3); expect_lit(3, 16'h4, 0, 0);

    // Edge qualification: held trigger steps once
    tick();
    trig[0] = 1'b1;
    repeat (10) tick();
    expect_lit(0, 16'h0001, 0, 0);
    trig[0] = 1'b0;
    // clear with a trigger edge: edge consumed
    tick();
    clr[0] = 1'b1; trig[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    tick();
    expect_lit(0, 16'h0000, 0, 0);
    trig[0] = 1'b0;
    // load with a trigger edge: edge consumed
    tick();
    lidx[0] = 4'd5; ld[0] = 1'b1; trig[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    tick();
    expect_lit(0, 16'h0020, 0, 0);
    trig[0] = 1'b0;

    // Width 12 ROLL, level trigger; out-of-range load ignored
    do_load(4, 4'd11, 1'b0);
    expect_lit(4, 16'h0800, 0, 1);
    do_load(4, 4'd13, 1'b0);
    expect_lit(4, 16'h0800, 0, 1);
    trig[4] = 1'b1;
    tick();
    expect_lit(4, 16'h0001, 1, 0);
    tick();
    tick();
    expect_lit(4, 16'h0004, 0, 0);
    trig[4] = 1'b0;

    // Asynchronous reset mid-run
    do_load(0, 4'd6, 1'b0);
    expect_lit(0, 16'h0040, 0, 0);
    tick();
    reset = 1'b0;
    expect_lit(0, 16'h0000, 0, 0);
    reset = 1'b1;
    pulse(0);
    expect_lit(0, 16'h0001, 0, 0);

    tick();
    tick();
    @(negedge clk);
    #1;
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
